convg_seq: RTL

- Frame sequencer for the parallel 3x3 Gaussian line-buffer convolution engine (convg8).
- Accepts a valid/ready pixel-beat stream of NO_PARALLEL_UNITS pixels per beat and drives the engine's pixel input, clrbuffer, rowend and stall.
- Flushes the pipeline with zero beats at frame end and presents engine results on a valid/ready output stream.
- Sits between the pixel fetch stage and the fusion/weighting stage.

---
 rtl/convg_pkg.sv | 26 ++
 rtl/convg_pos_cnt.sv | 54 +++++
 rtl/convg_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/convg_pkg.sv
// Shared types and helpers for the convg8 frame sequencer.
package convg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bit positions inside the engine's rowend bus.
  localparam int RE_NOT_LAST  = 0;
  localparam int RE_NOT_FIRST = 1;

  // Beats per image row.
  function automatic int calc_bpr(input int im_len, input int npu);
    return im_len / npu;
  endfunction

  // Beats per frame.
  function automatic int calc_total(input int im_len, input int im_rows, input int npu);
    return (im_len / npu) * im_rows;
  endfunction

endpackage

// File: rtl/convg_pos_cnt.sv
// Column/row position of the beat currently being advanced into the engine.
// Produces the row-edge flags for that beat and flags the last beat of a frame.
module convg_pos_cnt
  import convg_pkg::*;
#(
  parameter int BPR  = 130,
  parameter int ROWS = 520
) (
  input  logic       clk,
  input  logic       i_res,
  input  logic       i_clr,
  input  logic       i_adv,
  output logic [1:0] o_rowend,
  output logic       o_last_beat
);

  localparam int CW = $clog2(BPR) + 1;
  localparam int RW = $clog2(ROWS) + 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_col_wrap  = (r_col == CW'(BPR - 1));
  assign w_row_wrap  = (r_row == RW'(ROWS - 1));
  assign o_last_beat = w_col_wrap & w_row_wrap;

  // Position counters: wrap per row and per frame, keep running during flush.
  always_ff @(posedge clk or posedge i_res) begin
    if (i_res) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Row-edge flags for the beat at the current position.
  always_comb begin
    o_rowend               = '0;
    o_rowend[RE_NOT_LAST]  = ~w_col_wrap;
    o_rowend[RE_NOT_FIRST] = (r_col != '0);
  end

endmodule

// File: rtl/convg_seq.sv
// Frame sequencer in front of the convg8 line-buffer convolution engine.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | engine buffer clear (one cycle); returns to IDLE after an abort
// RUN   | feeding input beats into the engine
// FLUSH | feeding zero beats to drain the engine pipeline
// DONE  | one-cycle frame-complete pulse
module convg_seq
  import convg_pkg::*;
#(
  parameter int IM_LEN            = 520,
  parameter int IM_ROWS           = 520,
  parameter int NO_PARALLEL_UNITS = 4,
  parameter int CONV_LAT          = IM_LEN / NO_PARALLEL_UNITS + 2
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           start,
  input  logic                           abort,
  input  logic [8*NO_PARALLEL_UNITS-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [8*NO_PARALLEL_UNITS-1:0] conv_in,
  output logic                           conv_clrbuffer,
  output logic [1:0]                     conv_rowend,
  output logic                           conv_stall,
  input  logic [8*NO_PARALLEL_UNITS-1:0] conv_out,
  output logic [8*NO_PARALLEL_UNITS-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int BPR     = calc_bpr(IM_LEN, NO_PARALLEL_UNITS);
  localparam int TOTAL   = calc_total(IM_LEN, IM_ROWS, NO_PARALLEL_UNITS);
  localparam int ADV_MAX = TOTAL + CONV_LAT - 1;
  localparam int AW      = $clog2(ADV_MAX + 1) + 1;
  localparam int OW      = $clog2(TOTAL + 1) + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_abort_clr;
  logic          w_abort_clr_nxt;
  logic [AW-1:0] r_adv_cnt;
  logic [OW-1:0] r_out_cnt;
  logic          w_adv;
  logic          w_out_base;
  logic          w_blocked;
  logic          w_out_xfer;
  logic          w_cnt_clr;
  logic          w_last_beat;
  logic [1:0]    w_rowend_cnt;

  // A new frame zeroes every counter; abort has priority over start.
  assign w_cnt_clr  = (r_state == ST_IDLE) & start & ~abort;
  assign w_out_xfer = out_valid & out_ready;
  assign conv_stall = (r_state == ST_CLEAR) ? 1'b0 : ~w_adv;
  assign busy       = (r_state != ST_IDLE);
  assign out_data   = conv_out;

  convg_pos_cnt #(
    .BPR  (BPR),
    .ROWS (IM_ROWS)
  ) u_pos_cnt (
    .clk         (clk),
    .i_res       (res),
    .i_clr       (w_cnt_clr),
    .i_adv       (w_adv),
    .o_rowend    (w_rowend_cnt),
    .o_last_beat (w_last_beat)
  );

  // State register plus the flag that sends an abort-triggered CLEAR back to IDLE.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= ST_IDLE;
      r_abort_clr <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_abort_clr <= w_abort_clr_nxt;
    end
  end

  // Advance and output-transfer counters.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_adv_cnt <= '0;
      r_out_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_adv_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_adv && (r_adv_cnt != AW'(ADV_MAX))) r_adv_cnt <= r_adv_cnt + 1'b1;
      if (w_out_xfer) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // Next state, handshakes and engine controls.
  // The engine result only changes when the engine advances, so in RUN a
  // result is offered only together with an input beat; otherwise a bubble
  // would send the same result twice.
  always_comb begin
    w_state_nxt     = r_state;
    w_abort_clr_nxt = r_abort_clr;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    w_adv           = 1'b0;
    w_blocked       = 1'b0;
    conv_in         = '0;
    conv_clrbuffer  = 1'b0;
    conv_rowend     = 2'b00;
    done            = 1'b0;
    w_out_base      = (r_adv_cnt >= AW'(CONV_LAT)) && (r_out_cnt < OW'(TOTAL));

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt     = ST_CLEAR;
          w_abort_clr_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        conv_clrbuffer = 1'b1;
        w_state_nxt    = r_abort_clr ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        out_valid   = w_out_base & in_valid;
        w_blocked   = out_valid & ~out_ready;
        in_ready    = ~w_blocked;
        w_adv       = in_valid & in_ready;
        conv_in     = in_data;
        conv_rowend = w_rowend_cnt;
        if (w_adv && w_last_beat) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        out_valid   = w_out_base;
        w_blocked   = out_valid & ~out_ready;
        w_adv       = ~w_blocked & (r_adv_cnt < AW'(ADV_MAX));
        conv_rowend = w_rowend_cnt;
        if ((r_adv_cnt == AW'(ADV_MAX)) && out_valid && out_ready) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt     = ST_CLEAR;
      w_abort_clr_nxt = 1'b1;
      done            = 1'b0;
    end
  end

endmodule
